uart_tx_periph: RTL and testbench

- Memory-mapped serial transmitter that responds to the CPU's existing sysbus memory cycles (CS, R_NW, load_MAR, MDR_bus), acting as a bus responder alongside the RAM and ROM.
- The CPU writes bytes into a small transmit FIFO.
- The block serialises each byte as an 8N1 frame on txd at a programmable bit rate.
- Status and configuration registers are readable back over sysbus.

---
 rtl/uart_tx_periph.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 serial transmitter on the sysbus: a small transmit FIFO,
// programmable bit period, status/config registers and a transmit-done interrupt.
module uart_tx_periph #(
  parameter int WORD_W     = 8,
  parameter int OP_W       = 3,
  parameter int BASE_ADDR  = 28,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 3
) (
  input  logic              clock,
  input  logic              reset,
  inout  wire  [WORD_W-1:0] sysbus,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  input  logic              MDR_bus,
  output logic              txd,
  output logic              tx_irq
);

  localparam int AW = WORD_W - OP_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(WORD_W);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [AW-1:0]     r_addr;
  logic [WORD_W-1:0] r_div;
  logic              r_tx_en;
  logic              r_irq_en;
  logic              r_ovf;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_baud;
  logic [WORD_W-1:0] r_div_q;
  logic [BW-1:0]     r_bit;
  logic [WORD_W-1:0] r_shift;
  logic              r_txd;

  logic              w_sel;
  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_reg;
  logic              w_full;
  logic              w_empty;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_baud_done;
  logic              w_busy;
  logic [WORD_W-1:0] w_rdata;

  assign w_sel      = (r_addr[AW-1:2] == BASE[AW-1:2]);
  assign w_reg      = r_addr[1:0];
  assign w_wr       = CS & ~R_NW & w_sel;
  assign w_rd       = CS & R_NW & MDR_bus & w_sel;
  assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_push_req = w_wr & (w_reg == 2'd0);
  // Full is judged before this edge's pop, so a same-edge pop never makes room.
  assign w_push     = w_push_req & ~w_full;
  assign w_busy     = (r_state != IDLE);
  assign w_baud_done = (r_baud == r_div_q);

  assign txd    = r_txd;
  assign tx_irq = r_irq_en & w_empty & ~w_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (load_MAR) begin
      r_addr <= sysbus[AW-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div    <= WORD_W'(DIV_RESET);
      r_tx_en  <= 1'b1;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_wr) begin
      case (w_reg)
        2'd0: if (w_full) r_ovf <= 1'b1;
        2'd1: r_ovf <= 1'b0;
        2'd2: r_div <= sysbus;
        2'd3: begin
          r_tx_en  <= sysbus[0];
          r_irq_en <= sysbus[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= sysbus;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_tx_en && !w_empty) begin
          w_state_next = START;
          w_pop        = 1'b1;
        end
      end
      START: if (w_baud_done) w_state_next = DATA;
      DATA:  if (w_baud_done && r_bit == BW'(WORD_W - 1)) w_state_next = STOP;
      STOP: begin
        if (w_baud_done) begin
          // Chain straight into the next frame when more data is waiting.
          if (r_tx_en && !w_empty) begin
            w_state_next = START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud  <= '0;
      r_div_q <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rp];
      r_div_q <= r_div;
      r_baud  <= '0;
      r_txd   <= 1'b0;
    end else begin
      case (r_state)
        START: begin
          if (w_baud_done) begin
            r_baud <= '0;
            r_bit  <= '0;
            r_txd  <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == BW'(WORD_W - 1)) begin
              r_txd <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_done) r_baud <= '0;
          else             r_baud <= r_baud + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      2'd1: begin
        w_rdata[0] = w_empty;
        w_rdata[1] = w_full;
        w_rdata[2] = w_busy;
        w_rdata[3] = r_ovf;
      end
      2'd2: w_rdata = r_div;
      2'd3: begin
        w_rdata[0] = r_tx_en;
        w_rdata[1] = r_irq_en;
      end
      default: ;
    endcase
  end

  assign sysbus = w_rd ? w_rdata : {WORD_W{1'bz}};

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: bus tasks, a txd frame monitor fed by
// an expected-byte queue, and one task per scenario.
module tb_uart_tx_periph;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_MAR;
  logic       CS;
  logic       R_NW;
  logic       MDR_bus;
  logic [7:0] bus_drv;
  logic       bus_en;
  wire  [7:0] sysbus;
  wire        txd;
  wire        tx_irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         per_q[$];
  int         start_q[$];

  assign sysbus = bus_en ? bus_drv : 8'bz;

  uart_tx_periph dut (
    .clock   (clock),
    .reset   (reset),
    .sysbus  (sysbus),
    .load_MAR(load_MAR),
    .CS      (CS),
    .R_NW    (R_NW),
    .MDR_bus (MDR_bus),
    .txd     (txd),
    .tx_irq  (tx_irq)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // driver tasks: all start and end 1ns after a rising edge
  task automatic set_addr(input logic [4:0] a);
    load_MAR = 1'b1; bus_en = 1'b1; bus_drv = {3'b000, a};
    @(posedge clock); #1;
    load_MAR = 1'b0; bus_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    CS = 1'b1; R_NW = 1'b0; bus_en = 1'b1; bus_drv = d;
    @(posedge clock); #1;
    CS = 1'b0; R_NW = 1'b1; bus_en = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d, output int c);
    CS = 1'b1; R_NW = 1'b1; MDR_bus = 1'b1; bus_en = 1'b0;
    #2;
    d = sysbus;
    c = cyc;
    @(posedge clock); #1;
    CS = 1'b0; MDR_bus = 1'b0;
  endtask

  // polls STATUS (address must already be 29) until not busy
  task automatic wait_idle(input string nm, output int c_idle);
    logic [7:0] st;
    int c;
    c_idle = -1;
    for (int i = 0; i < 3000; i++) begin
      rd(st, c);
      if (st[2] == 1'b0) begin
        c_idle = c;
        break;
      end
    end
    if (c_idle < 0) begin
      total++; bad++;
      $display("FAIL %s: busy never cleared within bound, required idle", nm);
    end
  endtask

  // scoreboard: checks each txd frame against the expected queue
  task automatic mon_frame();
    logic [7:0] d;
    int p, errs;
    logic e, aborted;
    start_q.push_back(cyc);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
      for (int i = 0; i < 400 && txd !== 1'b1; i++) @(negedge clock);
      return;
    end
    d = exp_q.pop_front();
    p = per_q.pop_front();
    errs = 0;
    aborted = 1'b0;
    for (int b = 0; b < 10 && !aborted; b++) begin
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      for (int k = 0; k < p; k++) begin
        if (!(b == 0 && k == 0)) @(negedge clock);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (txd !== e) errs++;
      end
    end
    if (!aborted) begin
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL frame_%02h: %0d wrong txd samples, required 0 (period %0d)", d, errs, p);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && txd === 1'b0) mon_frame();
    end
  end

  task automatic test_reset();
    logic [7:0] d;
    int c;
    reset = 1'b1; load_MAR = 1'b0; CS = 1'b0; R_NW = 1'b1; MDR_bus = 1'b0;
    bus_en = 1'b0; bus_drv = '0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b, required 1", txd); end
    total++;
    if (tx_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b, required 0", tx_irq); end
    reset = 1'b0;
    @(posedge clock); #1;
    set_addr(5'd29);
    rd(d, c);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL reset_status: got %h, required 01", d); end
    set_addr(5'd30);
    rd(d, c);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL reset_divisor: got %h, required 03", d); end
    set_addr(5'd31);
    rd(d, c);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL reset_ctrl: got %h, required 01", d); end
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    int c, c0, ci;
    set_addr(5'd28);
    exp_q.push_back(8'hA5); per_q.push_back(4);
    wr(8'hA5);
    c0 = cyc;
    set_addr(5'd29);
    rd(d, c);
    total++;
    if (d !== 8'h05) begin bad++; $display("FAIL single_status_busy: got %h, required 05", d); end
    wait_idle("single_idle", ci);
    total++;
    if (ci != c0 + 41) begin bad++; $display("FAIL single_busy_len: idle at +%0d, required +41", ci - c0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int c, ci;
    start_q.delete();
    set_addr(5'd28);
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i)); per_q.push_back(4);
    end
    for (int i = 1; i <= 6; i++) wr(8'(i));
    set_addr(5'd29);
    rd(d, c);
    total++;
    if (d !== 8'h0E) begin bad++; $display("FAIL b2b_overflow_status: got %h, required 0E", d); end
    wr(8'h00);
    rd(d, c);
    total++;
    if (d !== 8'h06) begin bad++; $display("FAIL b2b_ovf_clear: got %h, required 06", d); end
    wait_idle("b2b_idle", ci);
    total++;
    if (start_q.size() != 5) begin
      bad++; $display("FAIL b2b_frame_count: got %0d, required 5", start_q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        total++;
        if (start_q[i] - start_q[i-1] != 40) begin
          bad++; $display("FAIL b2b_gap_%0d: got %0d cycles, required 40", i, start_q[i] - start_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_divisor_change();
    logic [7:0] d;
    int c, ci;
    set_addr(5'd28);
    exp_q.push_back(8'h11); per_q.push_back(4);
    exp_q.push_back(8'h22); per_q.push_back(1);
    wr(8'h11);
    wr(8'h22);
    set_addr(5'd30);
    wr(8'h00);
    rd(d, c);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL div_readback: got %h, required 00", d); end
    set_addr(5'd29);
    wait_idle("div_idle", ci);
    set_addr(5'd30);
    wr(8'h03);
  endtask

  task automatic test_bus_read();
    logic [7:0] d;
    int c;
    set_addr(5'd29);
    CS = 1'b1; R_NW = 1'b1; MDR_bus = 1'b0; bus_en = 1'b1; bus_drv = 8'h5A;
    #2;
    total++;
    if (sysbus !== 8'h5A) begin bad++; $display("FAIL hiz_no_mdr: got %h, required 5A (bus released)", sysbus); end
    @(posedge clock); #1;
    CS = 1'b0; bus_en = 1'b0;
    set_addr(5'd5);
    CS = 1'b1; R_NW = 1'b1; MDR_bus = 1'b1; bus_en = 1'b1; bus_drv = 8'hA3;
    #2;
    total++;
    if (sysbus !== 8'hA3) begin bad++; $display("FAIL hiz_unsel: got %h, required A3 (bus released)", sysbus); end
    @(posedge clock); #1;
    CS = 1'b0; MDR_bus = 1'b0; bus_en = 1'b0;
    set_addr(5'd28);
    rd(d, c);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL data_read: got %h, required 00", d); end
  endtask

  task automatic test_ctrl_irq();
    logic [7:0] d;
    int c, ci, hi;
    set_addr(5'd31);
    wr(8'h02);
    set_addr(5'd28);
    exp_q.push_back(8'hAA); per_q.push_back(4);
    exp_q.push_back(8'h55); per_q.push_back(4);
    wr(8'hAA);
    wr(8'h55);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (txd === 1'b1 && tx_irq === 1'b0) hi++;
    end
    total++;
    if (hi != 20) begin bad++; $display("FAIL ctrl_hold: txd high/irq low %0d cycles, required 20", hi); end
    set_addr(5'd29);
    rd(d, c);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ctrl_status_held: got %h, required 00", d); end
    set_addr(5'd31);
    wr(8'h03);
    set_addr(5'd29);
    wait_idle("ctrl_idle", ci);
    total++;
    if (tx_irq !== 1'b1) begin bad++; $display("FAIL irq_done: got %b, required 1", tx_irq); end
    set_addr(5'd31);
    wr(8'h01);
    total++;
    if (tx_irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b, required 0", tx_irq); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int c, hi;
    set_addr(5'd30);
    wr(8'h05);
    set_addr(5'd28);
    exp_q.push_back(8'h3C); per_q.push_back(6);
    wr(8'h3C);
    wr(8'h0F);
    repeat (26) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL midframe_txd: got %b, required 1", txd); end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete(); per_q.delete();
    set_addr(5'd29);
    rd(d, c);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL midframe_status: got %h, required 01", d); end
    set_addr(5'd30);
    rd(d, c);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL midframe_divisor: got %h, required 03", d); end
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (txd === 1'b1) hi++;
    end
    total++;
    if (hi != 60) begin bad++; $display("FAIL midframe_no_resume: txd high %0d cycles, required 60", hi); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_divisor_change();
    test_bus_read();
    test_ctrl_irq();
    test_reset_midframe();
    repeat (5) @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL frames_outstanding: got %0d, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
